// File: rtl/uart_txrx.sv
// Full-duplex UART: a TX serializer and an RX deserializer sharing one bit period,
// with optional parity, 1-2 stop bits and framing/parity/overrun detection.
module uart_txrx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_tx,
  input  logic                 serial_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD        = (PARITY_ODD != 0);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never depends on ready, and the producer holds its data until that edge.

  tx_state_t              tx_state, tx_next;
  logic [CNT_W-1:0]       tx_cnt;
  logic [IDX_W-1:0]       tx_idx;
  logic [DATA_BITS-1:0]   tx_buf;
  logic                   tx_last;

  assign tx_last = (tx_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_buf   <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_next != tx_state || tx_last) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + CNT_W'(1);
      if (tx_next != tx_state) tx_idx <= '0;
      else if (tx_last)        tx_idx <= tx_idx + IDX_W'(1);
      if (tx_state == TX_IDLE && tx_valid) tx_buf <= tx_data;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (tx_valid) tx_next = TX_START;
      TX_START:  if (tx_last) tx_next = TX_DATA;
      TX_DATA:   if (tx_last && tx_idx == DATA_LAST) tx_next = HAS_PARITY ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_last) tx_next = TX_STOP;
      TX_STOP:   if (tx_last && tx_idx == STOP_LAST) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_ready  = 1'b0;
    serial_tx = 1'b1;
    case (tx_state)
      TX_IDLE:   tx_ready  = 1'b1;
      TX_START:  serial_tx = 1'b0;
      TX_DATA:   serial_tx = tx_buf[tx_idx];
      TX_PARITY: serial_tx = (^tx_buf) ^ ODD;
      default:   ;
    endcase
  end

  // The line is asynchronous, so every RX decision uses the second synchronizer flop.
  logic rx_s1, rx_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= serial_rx;
      rx_s2 <= rx_s1;
    end
  end

  rx_state_t              rx_state, rx_next;
  logic [CNT_W-1:0]       rx_cnt;
  logic [IDX_W-1:0]       rx_idx;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_par_bit;
  logic                   rx_last, rx_half, rx_done, rx_par_bad;

  assign rx_last = (rx_cnt == CNT_LAST);
  assign rx_half = (rx_cnt == CNT_HALF);

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      rx_state <= rx_next;
      if (rx_next != rx_state || rx_last) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + CNT_W'(1);
      if (rx_next != rx_state) rx_idx <= '0;
      else if (rx_last)        rx_idx <= rx_idx + IDX_W'(1);
      if (rx_state == RX_DATA && rx_last) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
      if (rx_state == RX_PARITY && rx_last) rx_par_bit <= rx_s2;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rx_s2) rx_next = RX_START;
      RX_START:  if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_last && rx_idx == DATA_LAST) rx_next = HAS_PARITY ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_last) rx_next = RX_STOP;
      RX_STOP:   if (rx_last) rx_next = rx_s2 ? RX_IDLE : RX_BREAK;
      RX_BREAK:  if (rx_s2) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done    = (rx_state == RX_STOP) && rx_last;
    rx_par_bad = HAS_PARITY && (rx_par_bit != ((^rx_shift) ^ ODD));
  end

  // A completing frame may replace the held one only if it is being consumed this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (rx_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= rx_shift;
          rx_frame_err  <= !rx_s2;
          rx_parity_err <= rx_par_bad;
          rx_valid      <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Bench for uart_txrx: an 8N1 instance (4 clocks/bit) and a 7E2 instance (8 clocks/bit),
// stimulated by a line driver or loopback and checked by a frame scoreboard.
module tb_uart_txrx;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Instance A: 8 data bits, no parity, 1 stop, 4 clocks per bit
  logic [7:0] tx_data_a = '0;
  logic       tx_valid_a = 1'b0, tx_ready_a, serial_tx_a, serial_rx_a;
  logic       line_a = 1'b1, loop_a = 1'b0;
  logic [7:0] rx_data_a;
  logic       rx_valid_a, rx_ready_a = 1'b1, rx_frame_err_a, rx_parity_err_a, rx_overrun_a;
  assign serial_rx_a = loop_a ? serial_tx_a : line_a;

  // Instance B: 7 data bits, even parity, 2 stop bits, 8 clocks per bit
  logic [6:0] tx_data_b = '0;
  logic       tx_valid_b = 1'b0, tx_ready_b, serial_tx_b, serial_rx_b;
  logic       line_b = 1'b1, loop_b = 1'b0;
  logic [6:0] rx_data_b;
  logic       rx_valid_b, rx_ready_b = 1'b1, rx_frame_err_b, rx_parity_err_b, rx_overrun_b;
  assign serial_rx_b = loop_b ? serial_tx_b : line_b;

  uart_txrx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .serial_tx(serial_tx_a), .serial_rx(serial_rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .rx_frame_err(rx_frame_err_a), .rx_parity_err(rx_parity_err_a),
    .rx_overrun(rx_overrun_a));

  uart_txrx #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .serial_tx(serial_tx_b), .serial_rx(serial_rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .rx_frame_err(rx_frame_err_b), .rx_parity_err(rx_parity_err_b),
    .rx_overrun(rx_overrun_b));

  int n_checks = 0;
  int n_fail   = 0;
  int ov_a     = 0;
  int ov_b     = 0;
  // Entry layout: {frame_err, parity_err, data zero-extended to 9 bits}
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] got);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, got, $time);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (rx_overrun_a) ov_a++;
    if (rx_overrun_b) ov_b++;
    if (!reset && rx_valid_a && rx_ready_a) begin
      if (exp_a.size() == 0) note_fail("a_unexpected_frame", 32'({rx_frame_err_a, rx_parity_err_a, 1'b0, rx_data_a}));
      else chk("a_rx_frame", 32'({rx_frame_err_a, rx_parity_err_a, 1'b0, rx_data_a}), 32'(exp_a.pop_front()));
    end
    if (!reset && rx_valid_b && rx_ready_b) begin
      if (exp_b.size() == 0) note_fail("b_unexpected_frame", 32'({rx_frame_err_b, rx_parity_err_b, 2'b0, rx_data_b}));
      else chk("b_rx_frame", 32'({rx_frame_err_b, rx_parity_err_b, 2'b0, rx_data_b}), 32'(exp_b.pop_front()));
    end
  end

  task automatic send_tx(input int which, input logic [8:0] d);
    int guard = 0;
    while (!(which == 0 ? tx_ready_a : tx_ready_b) && guard < 500) begin
      hold(1);
      guard++;
    end
    if (!(which == 0 ? tx_ready_a : tx_ready_b)) begin
      note_fail("tx_ready_timeout", 32'(which));
      return;
    end
    if (which == 0) begin tx_data_a = d[7:0]; tx_valid_a = 1'b1; end
    else            begin tx_data_b = d[6:0]; tx_valid_b = 1'b1; end
    hold(1);
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    if (which == 0 && loop_a) exp_a.push_back({2'b00, 1'b0, d[7:0]});
    if (which == 1 && loop_b) exp_b.push_back({2'b00, 2'b00, d[6:0]});
  endtask

  // Cycle-exact waveform of one 8N1 frame on instance A, plus the ready timing around it.
  task automatic tx_wave_a(input logic [7:0] d);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    hold(1);
    tx_valid_a = 1'b0;
    tx_data_a  = ~d;
    if (loop_a) exp_a.push_back({2'b00, 1'b0, d});
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      chk($sformatf("a_tx_cycle%0d", j + 1), 32'(serial_tx_a), 32'(bits[j / 4]));
      if (j == 0 || j == 39) chk($sformatf("a_tx_busy%0d", j + 1), 32'(tx_ready_a), 32'd0);
    end
    @(negedge clock);
    chk("a_tx_ready_after_41", 32'(tx_ready_a), 32'd1);
    chk("a_tx_idle_high", 32'(serial_tx_a), 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic [7:0] d, input logic expect_it);
    if (expect_it) exp_a.push_back({2'b00, 1'b0, d});
    line_a = 1'b0;
    hold(4);
    for (int i = 0; i < 8; i++) begin line_a = d[i]; hold(4); end
    line_a = 1'b1;
    hold(8);
  endtask

  // Even parity: the flag is set exactly when the driven bit differs from XOR of the data.
  task automatic drive_b(input logic [6:0] d, input logic par, input logic stop1, input int brk_hold);
    exp_b.push_back({~stop1, par ^ (^d), 2'b00, d});
    line_b = 1'b0;
    hold(8);
    for (int i = 0; i < 7; i++) begin line_b = d[i]; hold(8); end
    line_b = par;
    hold(8);
    line_b = stop1;
    hold(8);
    if (brk_hold > 0) begin line_b = 1'b0; hold(8 + brk_hold); end
    else              begin line_b = 1'b1; hold(8); end
    line_b = 1'b1;
    hold(16);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 3000) begin
      hold(1);
      guard++;
    end
    while (exp_a.size() != 0) note_fail("a_missing_frame", 32'(exp_a.pop_front()));
    while (exp_b.size() != 0) note_fail("b_missing_frame", 32'(exp_b.pop_front()));
    hold(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] rd;
    logic       rp, rs;
    logic       seen;

    hold(3);
    @(negedge clock);
    chk("rst_serial_tx_a", 32'(serial_tx_a), 32'd1);
    chk("rst_tx_ready_a", 32'(tx_ready_a), 32'd1);
    chk("rst_rx_valid_a", 32'(rx_valid_a), 32'd0);
    chk("rst_rx_data_a", 32'(rx_data_a), 32'd0);
    chk("rst_err_flags_a", 32'({rx_frame_err_a, rx_parity_err_a, rx_overrun_a}), 32'd0);
    chk("rst_serial_tx_b", 32'(serial_tx_b), 32'd1);
    chk("rst_rx_valid_b", 32'(rx_valid_b), 32'd0);
    chk("rst_err_flags_b", 32'({rx_frame_err_b, rx_parity_err_b, rx_overrun_b}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    hold(2);

    loop_a = 1'b1;
    tx_wave_a(8'hA5);
    send_tx(0, 9'h000);
    send_tx(0, 9'h0FF);
    send_tx(0, 9'h03C);
    for (int i = 0; i < 6; i++) send_tx(0, 9'($urandom_range(0, 255)));
    wait_drain();

    drive_b(7'h41, 1'b1, 1'b1, 0);
    drive_b(7'h41, 1'b0, 1'b1, 0);
    drive_b(7'h55, 1'b0, 1'b0, 20);
    for (int i = 0; i < 8; i++) begin
      rd = 7'($urandom_range(0, 127));
      rp = (^rd) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 4) != 0);
      drive_b(rd, rp, rs, 0);
    end
    wait_drain();

    loop_b = 1'b1;
    for (int i = 0; i < 4; i++) send_tx(1, 9'($urandom_range(0, 127)));
    wait_drain();
    loop_b = 1'b0;

    loop_a     = 1'b0;
    rx_ready_a = 1'b0;
    ov_a       = 0;
    drive_a(8'h11, 1'b1);
    drive_a(8'h22, 1'b0);
    hold(4);
    @(negedge clock);
    chk("a_overrun_keeps_data", 32'(rx_data_a), 32'h11);
    chk("a_overrun_keeps_valid", 32'(rx_valid_a), 32'd1);
    chk("a_overrun_pulses", 32'(ov_a), 32'd1);
    @(posedge clock);
    #1;
    rx_ready_a = 1'b1;
    hold(4);

    line_a = 1'b0;
    hold(1);
    line_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (rx_valid_a) seen = 1'b1;
    end
    chk("a_glitch_no_valid", 32'(seen), 32'd0);
    hold(2);

    loop_a = 1'b1;
    fork
      send_tx(0, 9'h0C3);
      begin
        line_b = 1'b0; hold(8);
        line_b = 1'b1; hold(8);
        line_b = 1'b0; hold(8);
      end
    join
    reset  = 1'b1;
    line_b = 1'b1;
    exp_a.delete();
    hold(1);
    @(negedge clock);
    chk("midrst_serial_tx_a", 32'(serial_tx_a), 32'd1);
    chk("midrst_tx_ready_a", 32'(tx_ready_a), 32'd1);
    chk("midrst_rx_valid_a", 32'(rx_valid_a), 32'd0);
    chk("midrst_rx_valid_b", 32'(rx_valid_b), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rx_valid_a || rx_valid_b) seen = 1'b1;
    end
    chk("postrst_no_valid", 32'(seen), 32'd0);
    @(posedge clock);
    #1;
    send_tx(0, 9'h05A);
    drive_b(7'h2B, ^(7'h2B), 1'b1, 0);
    wait_drain();

    chk("b_never_overruns", 32'(ov_b), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
